// File: rtl/csr_file_wr.sv
// csr_file_wr: machine-mode CSR read-modify-write unit with trap-entry and mret state updates.
// Accept -> EXEC (read, compute, commit) -> RESP (response strobe), three cycles per operation.
module csr_file_wr #(
   parameter logic [31:0] HART_ID     = 32'h0,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  funct3,
   input  logic [11:0] csr_addr,
   input  logic [31:0] rs1_data,
   input  logic [4:0]  rs1_uimm,
   output logic        resp_valid,
   output logic [31:0] rd_data,
   output logic        illegal,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret_valid,
   output logic [31:0] mtvec_out,
   output logic [31:0] mepc_out,
   output logic        mstatus_mie,
   output logic [31:0] mie_out
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t      state_q, state_d;
   logic [1:0]  op_q;
   logic [11:0] addr_q;
   logic [31:0] opnd_q;
   logic        wr_q;
   logic        ms_mie_q, ms_mpie_q;
   logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, rd_q;
   logic        ill_q;
   logic [31:0] old, nv;
   logic        known, legal, we;
   always_comb begin
      old   = '0;
      known = 1'b1;
      case (addr_q)
         12'h300: old = {19'b0, 2'b11, 3'b0, ms_mpie_q, 3'b0, ms_mie_q, 3'b0};
         12'h301: old = MISA_VALUE;
         12'h304: old = mie_q;
         12'h305: old = mtvec_q;
         12'h340: old = mscratch_q;
         12'h341: old = mepc_q;
         12'h342: old = mcause_q;
         12'h343: old = mtval_q;
         12'hF14: old = HART_ID;
         12'h306, 12'h344, 12'hF11, 12'hF12, 12'hF13: old = '0;
         default: known = 1'b0;
      endcase
   end
   assign nv    = op_q[0] ? (op_q[1] ? old & ~opnd_q : opnd_q) : old | opnd_q;
   assign legal = known && op_q != 2'b00 && !(addr_q[11:4] == 8'hF1 && wr_q);
   // A trap in EXEC aborts the operation, so it never commits.
   assign we    = state_q == EXEC && legal && wr_q && !trap_valid;
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   always_comb
      state_d = state_q == IDLE ? ((req_valid && req_ready) ? EXEC : IDLE)
              : (state_q == EXEC && !trap_valid) ? RESP : IDLE;
   always_comb begin
      req_ready  = state_q == IDLE && !trap_valid && !rst;
      resp_valid = state_q == RESP;
      illegal    = resp_valid && ill_q;
      rd_data    = rd_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op_q   <= '0;
         addr_q <= '0;
         opnd_q <= '0;
         wr_q   <= 1'b0;
         rd_q   <= '0;
         ill_q  <= 1'b0;
      end else begin
         if (req_valid && req_ready) begin
            op_q   <= funct3[1:0];
            addr_q <= csr_addr;
            opnd_q <= funct3[2] ? {27'b0, rs1_uimm} : rs1_data;
            wr_q   <= funct3[1:0] == 2'b01 || rs1_uimm != 5'd0;
         end
         if (state_q == EXEC) begin
            rd_q  <= legal ? old : '0;
            ill_q <= !legal;
         end
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ms_mie_q   <= 1'b0;
         ms_mpie_q  <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RESET & ~32'h3;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         if (trap_valid) begin
            mepc_q    <= trap_pc & ~32'h3;
            mcause_q  <= trap_cause;
            mtval_q   <= trap_tval;
            ms_mpie_q <= ms_mie_q;
            ms_mie_q  <= 1'b0;
         end else if (mret_valid) begin
            ms_mie_q  <= ms_mpie_q;
            ms_mpie_q <= 1'b1;
         end else if (we && addr_q == 12'h300) begin
            ms_mie_q  <= nv[3];
            ms_mpie_q <= nv[7];
         end
         if (we && addr_q == 12'h304) mie_q      <= nv & 32'h0000_0888;
         if (we && addr_q == 12'h305) mtvec_q    <= nv & ~32'h3;
         if (we && addr_q == 12'h340) mscratch_q <= nv;
         if (we && addr_q == 12'h341) mepc_q     <= nv & ~32'h3;
         if (we && addr_q == 12'h342) mcause_q   <= nv;
         if (we && addr_q == 12'h343) mtval_q    <= nv;
      end
   assign mtvec_out   = mtvec_q;
   assign mepc_out    = mepc_q;
   assign mstatus_mie = ms_mie_q;
   assign mie_out     = mie_q;
endmodule

// File: tb/tb_csr_file_wr.sv
// tb_csr_file_wr: randomized scoreboard bench for csr_file_wr against an architectural CSR model.
module tb_csr_file_wr;
   localparam logic [31:0] HID  = 32'h0000_0005;
   localparam logic [31:0] MTR  = 32'h0000_0103;
   localparam logic [31:0] MISA = 32'h4000_0100;
   logic        clk = 0, rst = 1;
   logic        req_valid = 0, req_ready, resp_valid, illegal, trap_valid = 0, mret_valid = 0, mstatus_mie;
   logic [2:0]  funct3 = 0;
   logic [11:0] csr_addr = 0;
   logic [31:0] rs1_data = 0, rd_data, trap_pc = 0, trap_cause = 0, trap_tval = 0;
   logic [31:0] mtvec_out, mepc_out, mie_out;
   logic [4:0]  rs1_uimm = 0;
   int n_cmp = 0, n_bad = 0;
   logic [32:0] exp_q[$];
   logic [31:0] m_ms, m_mie, m_mtvec, m_scr, m_mepc, m_mcause, m_mtval;
   csr_file_wr #(.HART_ID(HID), .MTVEC_RESET(MTR), .MISA_VALUE(MISA)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .funct3(funct3),
      .csr_addr(csr_addr), .rs1_data(rs1_data), .rs1_uimm(rs1_uimm), .resp_valid(resp_valid),
      .rd_data(rd_data), .illegal(illegal), .trap_valid(trap_valid), .trap_pc(trap_pc),
      .trap_cause(trap_cause), .trap_tval(trap_tval), .mret_valid(mret_valid),
      .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mstatus_mie(mstatus_mie), .mie_out(mie_out));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin : mon
      logic [32:0] e;
      if (!rst && resp_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got rd_data %h with no pending request at %0t", rd_data, $time);
         end else begin
            e = exp_q.pop_front();
            chk("rd_data", rd_data, e[31:0]);
            chk("illegal", {31'b0, illegal}, {31'b0, e[32]});
         end
      end
   end
   task automatic m_reset();
      m_ms = 32'h1800; m_mie = 0; m_mtvec = MTR & ~32'h3;
      m_scr = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
   endtask
   task automatic m_access(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                           input logic [4:0] u, output logic [32:0] r);
      logic [31:0] opnd, old, nv;
      logic known, wr, ill;
      opnd  = f3[2] ? 32'(u) : rs1;
      wr    = (f3 == 3'b001 || f3 == 3'b101) || u != 0;
      known = 1;
      case (a)
         12'h300: old = m_ms;
         12'h301: old = MISA;
         12'h304: old = m_mie;
         12'h305: old = m_mtvec;
         12'h340: old = m_scr;
         12'h341: old = m_mepc;
         12'h342: old = m_mcause;
         12'h343: old = m_mtval;
         12'hF14: old = HID;
         12'h306, 12'h344, 12'hF11, 12'hF12, 12'hF13: old = 0;
         default: begin old = 0; known = 0; end
      endcase
      ill = !known || (a >= 12'hF11 && a <= 12'hF14 && wr);
      case (f3)
         3'b001, 3'b101: nv = opnd;
         3'b010, 3'b110: nv = old | opnd;
         default:        nv = old & ~opnd;
      endcase
      if (!ill && wr)
         case (a)
            12'h300: m_ms    = 32'h1800 | (nv & 32'h88);
            12'h304: m_mie   = nv & 32'h888;
            12'h305: m_mtvec = {nv[31:2], 2'b00};
            12'h340: m_scr   = nv;
            12'h341: m_mepc  = {nv[31:2], 2'b00};
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            default: ;
         endcase
      r = {ill, ill ? 32'h0 : old};
   endtask
   task automatic m_trap(input logic [31:0] pc, input logic [31:0] c, input logic [31:0] tv);
      m_mepc = {pc[31:2], 2'b00}; m_mcause = c; m_mtval = tv;
      m_ms = 32'h1800 | (m_ms[3] ? 32'h80 : 32'h0);
   endtask
   task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                        input logic [4:0] u, input bit push);
      logic [32:0] r;
      int k = 0;
      @(negedge clk);
      req_valid = 1; funct3 = f3; csr_addr = a; rs1_data = rs1; rs1_uimm = u;
      #1;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
         req_valid = 0;
         return;
      end
      if (push) begin
         m_access(f3, a, rs1, u, r);
         exp_q.push_back(r);
      end
      @(posedge clk);
      #1 req_valid = 0;
   endtask
   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(negedge clk);
         #2;
         k++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL resp_timeout: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask
   task automatic check_outs();
      chk("mtvec_out", mtvec_out, m_mtvec);
      chk("mepc_out", mepc_out, m_mepc);
      chk("mstatus_mie", {31'b0, mstatus_mie}, {31'b0, m_ms[3]});
      chk("mie_out", mie_out, m_mie);
   endtask
   task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] u);
      issue(f3, a, rs1, u, 1);
      drain();
      check_outs();
   endtask
   task automatic trap(input logic [31:0] pc, input logic [31:0] c, input logic [31:0] tv);
      @(negedge clk);
      trap_valid = 1; trap_pc = pc; trap_cause = c; trap_tval = tv;
      @(negedge clk);
      trap_valid = 0;
      m_trap(pc, c, tv);
   endtask
   task automatic mret();
      @(negedge clk);
      mret_valid = 1;
      @(negedge clk);
      mret_valid = 0;
      m_ms = 32'h1880 | (m_ms[7] ? 32'h8 : 32'h0);
   endtask
   task automatic check_reset_outs();
      chk("rst_req_ready", {31'b0, req_ready}, 0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 0);
      chk("rst_illegal", {31'b0, illegal}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_mtvec", mtvec_out, 32'h0000_0100);
      chk("rst_mepc", mepc_out, 0);
      chk("rst_mie", mie_out, 0);
      chk("rst_mstatus_mie", {31'b0, mstatus_mie}, 0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [11:0] addrs [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h000};
      logic [2:0] f3s [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
      m_reset();
      repeat (3) @(negedge clk);
      #1 check_reset_outs();
      rst = 0;
      check_outs();
      // read mstatus, with explicit +2 latency check
      issue(3'b010, 12'h300, 32'h0, 5'd0, 1);
      @(negedge clk); #2 chk("lat_exec", {31'b0, resp_valid}, 0);
      @(negedge clk); #2 chk("lat_resp", {31'b0, resp_valid}, 1);
      drain();
      op(3'b001, 12'h340, 32'hDEADBEEF, 5'd1);
      op(3'b011, 12'h340, 32'h0000FFFF, 5'd1);
      op(3'b010, 12'h340, 32'h0, 5'd0);
      op(3'b101, 12'h305, 32'h0, 5'h1F);
      chk("mtvec_1c", mtvec_out, 32'h0000_001C);
      op(3'b001, 12'h341, 32'h12345677, 5'd1);
      chk("mepc_align", mepc_out, 32'h1234_5674);
      op(3'b001, 12'hF14, 32'h1, 5'd1);
      op(3'b010, 12'hF14, 32'h0, 5'd0);
      op(3'b001, 12'h7C0, 32'h1, 5'd1);
      op(3'b110, 12'h300, 32'h0, 5'd8);
      chk("mie_set", {31'b0, mstatus_mie}, 1);
      trap(32'h104, 32'hB, 32'h77);
      check_outs();
      chk("trap_mepc", mepc_out, 32'h104);
      chk("trap_mie", {31'b0, mstatus_mie}, 0);
      op(3'b010, 12'h300, 32'h0, 5'd0);
      op(3'b010, 12'h342, 32'h0, 5'd0);
      mret();
      chk("mret_mie", {31'b0, mstatus_mie}, 1);
      op(3'b010, 12'h300, 32'h0, 5'd0);
      // trap during EXEC aborts the write and the response
      op(3'b001, 12'h340, 32'h11112222, 5'd1);
      issue(3'b001, 12'h340, 32'h99999999, 5'd1, 0);
      @(negedge clk);
      trap_valid = 1; trap_pc = 32'h208; trap_cause = 32'h2; trap_tval = 32'h0;
      @(negedge clk);
      trap_valid = 0;
      m_trap(32'h208, 32'h2, 32'h0);
      repeat (3) @(negedge clk);
      op(3'b010, 12'h340, 32'h0, 5'd0);
      // trap blocks acceptance in IDLE
      @(negedge clk);
      req_valid = 1; funct3 = 3'b001; csr_addr = 12'h340; rs1_data = 32'h5555; rs1_uimm = 5'd1;
      trap_valid = 1; trap_pc = 32'h300; trap_cause = 32'h3; trap_tval = 32'h9;
      #1 chk("trap_req_ready", {31'b0, req_ready}, 0);
      @(negedge clk);
      req_valid = 0; trap_valid = 0;
      m_trap(32'h300, 32'h3, 32'h9);
      repeat (3) @(negedge clk);
      op(3'b010, 12'h340, 32'h0, 5'd0);
      op(3'b010, 12'h343, 32'h0, 5'd0);
      // reset in the middle of EXEC
      op(3'b001, 12'h304, 32'hFFFF_FFFF, 5'd1);
      issue(3'b001, 12'h340, 32'hABCD, 5'd1, 0);
      @(negedge clk);
      rst = 1;
      #1 check_reset_outs();
      m_reset();
      @(negedge clk);
      rst = 0;
      check_outs();
      for (int i = 0; i < 300; i++) begin
         logic [31:0] rs1;
         logic [4:0] u;
         rs1 = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
         u = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
         op(f3s[$urandom_range(5)], addrs[$urandom_range(15)], rs1, u);
         if (i % 10 == 3) trap($urandom, $urandom, $urandom);
         if (i % 10 == 7) mret();
      end
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
